// File: rtl/xbar_pkt_ser_pkg.sv
// xbar_pkt_ser_pkg: shared types and constants for the crossbar packet serializer
package xbar_pkt_ser_pkg;
  localparam int XBAR_PORTS = 8;
  typedef enum logic [2:0] {SER_IDLE, SER_START, SER_DATA, SER_PARITY, SER_STOP} ser_state_e;
  function automatic int ser_frame_bits(int data_w, int parity_en);
    return data_w + 2 + parity_en;
  endfunction
endpackage

// File: rtl/xbar_pkt_ser_if.sv
// xbar_pkt_ser_if: parallel word handshake in, serial lanes and status out
interface xbar_pkt_ser_if import xbar_pkt_ser_pkg::*; #(
  parameter int CHANNELS = XBAR_PORTS,
  parameter int DATA_W = 8
);
  logic [CHANNELS-1:0] in_valid;
  logic [CHANNELS-1:0] in_ready;
  logic [CHANNELS*DATA_W-1:0] in_data;
  logic [CHANNELS-1:0] serial_out;
  logic [CHANNELS-1:0] busy;
  logic bit_tick;
  modport master (output in_valid, in_data, input in_ready, serial_out, busy, bit_tick);
  modport slave (input in_valid, in_data, output in_ready, serial_out, busy, bit_tick);
endinterface

// File: rtl/xbar_ser_chan.sv
// xbar_ser_chan: one lane's word FIFO, shift register and framing FSM
module xbar_ser_chan import xbar_pkt_ser_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN = 1
)(
  input  logic clk,
  input  logic rst,
  input  logic bit_tick,
  input  logic valid,
  input  logic [DATA_W-1:0] data,
  output logic ready,
  output logic serial_out,
  output logic busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] ILAST = IW'(DATA_W - 1);
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic [DATA_W-1:0] sh, sh_n, head;
  logic [IW-1:0] idx, idx_n;
  logic par, par_n, so_n, pop, push, empty;
  ser_state_e state, state_n;
  // extra pointer MSB distinguishes full from empty when the indices match
  assign empty = wptr == rptr;
  assign ready = !(wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0]);
  assign push = valid && ready;
  assign head = mem[rptr[AW-1:0]];
  assign busy = state != SER_IDLE;
  assign pop = bit_tick && !empty && (state == SER_IDLE || state == SER_STOP);
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      state <= SER_IDLE;
      sh <= '0;
      idx <= '0;
      par <= 1'b0;
      serial_out <= 1'b1;
    end else begin
      wptr <= wptr + (AW+1)'(push);
      rptr <= rptr + (AW+1)'(pop);
      state <= state_n;
      sh <= sh_n;
      idx <= idx_n;
      par <= par_n;
      serial_out <= so_n;
    end
  // parity is latched at load because the shift register loses the word
  always_comb begin
    state_n = state;
    sh_n = sh;
    idx_n = idx;
    par_n = par;
    so_n = serial_out;
    if (pop) begin
      sh_n = head;
      par_n = ^head;
      so_n = 1'b0;
      state_n = SER_START;
    end else if (bit_tick) begin
      case (state)
        SER_START: begin
          so_n = sh[0];
          idx_n = '0;
          state_n = SER_DATA;
        end
        SER_DATA: begin
          if (idx != ILAST) begin
            sh_n = sh >> 1;
            so_n = sh[1];
            idx_n = idx + 1'b1;
          end else begin
            so_n = PARITY_EN != 0 ? par : 1'b1;
            state_n = PARITY_EN != 0 ? SER_PARITY : SER_STOP;
          end
        end
        SER_PARITY: begin
          so_n = 1'b1;
          state_n = SER_STOP;
        end
        SER_STOP: begin
          so_n = 1'b1;
          state_n = SER_IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/xbar_pkt_ser.sv
// xbar_pkt_ser: shared bit-rate divider feeding CHANNELS independent lane serializers
module xbar_pkt_ser import xbar_pkt_ser_pkg::*; #(
  parameter int CHANNELS = XBAR_PORTS,
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV = 10,
  parameter int PARITY_EN = 1
)(
  input logic clk,
  input logic rst,
  xbar_pkt_ser_if.slave bus
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt;
  logic tick;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= cnt == LAST ? '0 : cnt + 1'b1;
  assign tick = !rst && cnt == LAST;
  assign bus.bit_tick = tick;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    xbar_ser_chan #(
      .DATA_W(DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH),
      .PARITY_EN(PARITY_EN)
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .bit_tick(tick),
      .valid(bus.in_valid[c]),
      .data(bus.in_data[c*DATA_W +: DATA_W]),
      .ready(bus.in_ready[c]),
      .serial_out(bus.serial_out[c]),
      .busy(bus.busy[c])
    );
  end
endmodule

// File: doc/xbar_pkt_ser.md
Name: xbar_pkt_ser

Overview:
Parametrised multi-channel packet serializer that drives the crossbar's serial inputs.
- Accepts parallel words per channel through a valid/ready handshake and buffers them in a per-channel FIFO.
- Emits each word as a framed, LSB-first serial stream at a bit rate set by an internal divider.
- Generalises the per-port serializer: CHANNELS, DATA_W, FIFO_DEPTH and divider are parameters; it adds buffering, backpressure, optional parity and a shared bit tick.

Parameters:
- CHANNELS, 8, number of serial lanes (matches xbar ports).
- DATA_W, 8, payload bits per word.
- FIFO_DEPTH, 4, words buffered per channel; power of 2, >=2.
- DIV, 10, clk cycles per serial bit; >=1.
- PARITY_EN, 1, 1 = append even-parity bit, 0 = no parity bit.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  CHANNELS  per-channel word valid.
- in_ready  out  CHANNELS  per-channel accept; = !fifo_full.
- in_data  in  CHANNELS*DATA_W  packed words, channel c at [c*DATA_W +: DATA_W].
- serial_out  out  CHANNELS  serial lines, idle high.
- busy  out  CHANNELS  1 while a frame is in progress (state != IDLE).
- bit_tick  out  1  one-cycle pulse at each bit boundary.

Behaviour:
- Reset (async, immediate): divider=0, all FIFOs empty, all FSMs IDLE, serial_out=all 1, busy=0, bit_tick=0, in_ready=all 1.
- Divider: cnt counts 0..DIV-1 and wraps. bit_tick=1 in the cycle cnt==DIV-1. With DIV=1, bit_tick is constantly 1 after reset.
- FIFO push: in_valid[c]&&in_ready[c] at a rising edge writes in_data slice c. No bypass; a pushed word is poppable from the next cycle.
- FIFO simultaneous push+pop: allowed when not full; occupancy unchanged. When full, in_ready=0, so push+pop in the same cycle cannot occur.
- Frame: START(0), DATA_W data bits LSB first, PARITY (XOR of data, even) if PARITY_EN, STOP(1).
  - Frame length F = DATA_W + 2 + PARITY_EN bits = F*DIV cycles.
- FSM per channel: IDLE -> START -> DATA -> [PARITY] -> STOP. All transitions occur only on bit_tick.
  - IDLE: on bit_tick && !empty: pop the head into the shift register, serial_out<=0, go to START.
  - START: on tick, drive bit0, bit index=0, go to DATA.
  - DATA: on tick, if index<DATA_W-1, shift and drive the next bit; else go to PARITY (drive parity) or to STOP (drive 1).
  - PARITY: on tick, drive 1, go to STOP.
  - STOP: on tick, if !empty pop and drive 0 (START, back-to-back, no idle bit); else drive 1 and go to IDLE.
- serial_out is registered. A level changes in the cycle after bit_tick and is held exactly DIV cycles.
- Channels are independent but share the tick. Frames started on the same tick stay bit-aligned.
- Reset mid-frame: the frame is aborted, the line returns high immediately, and buffered words are discarded.

Decomposition:
- xbar_pkg gains:
  - enum ser_state_e {SER_IDLE, SER_START, SER_DATA, SER_PARITY, SER_STOP};
  - function ser_frame_bits(DATA_W, PARITY_EN).
  - The existing ports constant is the default source for CHANNELS.
- Sub-module xbar_ser_chan: one channel's FIFO, shift register and FSM; inputs bit_tick.
- Top holds the divider and a generate loop of CHANNELS xbar_ser_chan instances.

Test Plan:
- Single word, DIV=10, PARITY_EN=1: push 8'hA5 on ch0 after reset -> serial_out[0] = 0,1,0,1,0,0,1,0,1,0,1, each level held 10 cycles. Total 110 cycles, busy[0]=1 throughout, then line idles at 1.
- Backpressure, FIFO_DEPTH=4: push on ch1 on 5 consecutive cycles after reset, before the first tick -> in_ready[1]=0 after the 4th push. The 5th word is accepted the cycle after the first pop.
- Back-to-back: push 8'h01 then 8'h80 on ch2 -> 220 contiguous cycles with no idle-high gap between the STOP of word 1 and the START of word 2. Parity bits are 1 and 1.
- Concurrent channels: same-cycle push of ch3=8'hFF and ch7=8'h00 -> both START on the same tick, bit-aligned. Both parity bits are 0. All other serial_out bits stay 1.
- Reset mid-frame: assert rst during the DATA bit 3 of ch0 with 2 words queued -> serial_out[0]=1 and busy[0]=0 in the same cycle, without waiting for a clock edge. After release, no frame is emitted and in_ready[0]=1.
- PARITY_EN=0, DIV=1: push 8'h3C -> frame 0,0,0,1,1,1,1,0,0,1 at one bit per cycle, 10 cycles total.
